// File: rtl/cm_lvl_burst_ctl_pkg.sv
// cm_pkg_lvl_burst: types and helpers shared by the level-driven burst controller.
// Holds the FSM state type, the u32 alias and the log2/clamp helpers.
package cm_pkg_lvl_burst;

    typedef logic [31:0] u32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_BURST
    } lvl_burst_st_t;

    // Bits needed to hold values 0..v-1, never less than one.
    function automatic u32 sclog2(input u32 v);
        u32 r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < {32'd0, v}) begin
                r = u32'(i + 1);
            end
        end
        return (r == '0) ? u32'(1) : r;
    endfunction

    function automatic u32 thr_clamp(input u32 v, input u32 cap);
        if (v == '0) begin
            return u32'(1);
        end
        if (v > cap) begin
            return cap;
        end
        return v;
    endfunction

endpackage

// File: rtl/cm_lvl_burst_ctl_if.sv
// cm_if_lvl: level report from a buffer (mst) to its consumer (slv).
// The consumer programs lvl_thr; the buffer answers with lvl_gte.
interface cm_if_lvl
    import cm_pkg_lvl_burst::*;
#(
    parameter u32 CAPACITY = 16
);
    localparam u32 LW = sclog2(CAPACITY + 1);

    logic          lim;
    logic [LW-1:0] lvl;
    logic          lvl_gte;
    logic [LW-1:0] lvl_thr;

    modport mst (
        output lim,
        output lvl,
        output lvl_gte,
        input  lvl_thr
    );

    modport slv (
        input  lim,
        input  lvl,
        input  lvl_gte,
        output lvl_thr
    );

endinterface

// File: rtl/cm_lvl_burst_ctl_tmr.sv
// cm_tmr: clearable, enabled up-counter with a terminal-count flag.
// Clear has priority over enable.
module cm_tmr #(
    parameter int unsigned W  = 4,
    parameter int unsigned TC = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_tc = (r_cnt == W'(TC));

endmodule

// File: rtl/cm_lvl_burst_ctl.sv
// cm_lvl_burst_ctl: waits for the buffer level to reach a threshold, then pops one burst.
// Define CM_LVL_BURST_TMO_EN to flush a partial burst after TMO_CYC stalled ARM cycles.
module cm_lvl_burst_ctl
    import cm_pkg_lvl_burst::*;
#(
    parameter u32  CAPACITY = 16,
    parameter u32  TMO_CYC  = 64,
    localparam u32 LW       = sclog2(CAPACITY + 1)
) (
    input  logic          clk,
    input  logic          rst,
    cm_if_lvl.slv         lvl_if,
    input  logic          i_en,
    input  logic [LW-1:0] i_cfg_thr,
    output logic          o_pop_vld,
    input  logic          i_pop_rdy,
    output logic          o_brst_act,
    output logic [LW-1:0] o_brst_len,
    output logic          o_brst_done,
    output logic          o_brst_tmo
);
    lvl_burst_st_t r_st;
    logic [LW-1:0] r_thr;
    logic [LW-1:0] r_rem;
    logic [LW-1:0] r_len;
    logic          r_settle;
    logic          r_tmo;

    logic [LW-1:0] w_thr_c;
    logic          w_hs;
    logic          w_last;
    logic          w_go;
    logic          w_flush;

    assign w_thr_c = LW'(thr_clamp(u32'(i_cfg_thr), CAPACITY));

    // lim means the source is empty, so requests are withheld until it refills
    assign o_pop_vld   = (r_st == ST_BURST) && !lvl_if.lim;
    assign w_hs        = o_pop_vld && i_pop_rdy;
    assign w_last      = w_hs && (r_rem == LW'(1));
    assign o_brst_done = w_last;
    assign o_brst_act  = (r_st == ST_BURST);
    assign o_brst_len  = r_len;
    assign o_brst_tmo  = r_tmo;

    assign lvl_if.lvl_thr = r_thr;

    // the first ARM cycle sees lvl_gte against the old threshold
    assign w_go = (r_st == ST_ARM) && !r_settle && lvl_if.lvl_gte;

`ifdef CM_LVL_BURST_TMO_EN
    localparam u32 TW = sclog2(TMO_CYC + 1);

    logic w_tmo_tc;
    logic w_tmo_clr;
    logic w_tmo_en;

    assign w_tmo_clr = (r_st != ST_ARM) || (lvl_if.lvl == '0);
    assign w_tmo_en  = (r_st == ST_ARM) && (lvl_if.lvl != '0)
                     && !lvl_if.lvl_gte;

    cm_tmr #(
        .W  (TW),
        .TC (TMO_CYC - 1)
    ) u_tmr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_tmo_clr),
        .i_en  (w_tmo_en),
        .o_tc  (w_tmo_tc)
    );

    assign w_flush = (r_st == ST_ARM) && w_tmo_tc
                   && (lvl_if.lvl != '0) && !w_go;
`else
    assign w_flush = 1'b0;

    // TMO_CYC has no effect when the timeout is compiled out
    if (TMO_CYC == 0) begin : g_tmo_off
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st     <= ST_IDLE;
            r_thr    <= LW'(CAPACITY);
            r_rem    <= '0;
            r_len    <= '0;
            r_settle <= 1'b0;
            r_tmo    <= 1'b0;
        end else begin
            unique case (r_st)
                ST_IDLE: begin
                    if (i_en) begin
                        r_thr    <= w_thr_c;
                        r_settle <= 1'b1;
                        r_st     <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    r_settle <= 1'b0;
                    if (w_go) begin
                        r_rem <= r_thr;
                        r_len <= r_thr;
                        r_tmo <= 1'b0;
                        r_st  <= ST_BURST;
                    end else if (w_flush) begin
                        r_rem <= lvl_if.lvl;
                        r_len <= lvl_if.lvl;
                        r_tmo <= 1'b1;
                        r_st  <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (w_hs && (r_rem != '0)) begin
                        r_rem <= r_rem - LW'(1);
                    end
                    if (w_last) begin
                        if (i_en) begin
                            r_thr    <= w_thr_c;
                            r_settle <= 1'b1;
                            r_st     <= ST_ARM;
                        end else begin
                            r_st <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_st <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cm_lvl_burst_ctl.sv
// tb_cm_lvl_burst_ctl: directed bench with a transaction-level model of the burst controller.
// Builds with or without CM_LVL_BURST_TMO_EN; the timeout scenario adapts to the build.
module tb_cm_lvl_burst_ctl;

    localparam int CAP = 16;
    localparam int TMO = 8;
    localparam int LW  = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [LW-1:0] cfg;
    logic          pop_vld;
    logic          pop_rdy;
    logic          act;
    logic [LW-1:0] len;
    logic          done;
    logic          tmo;

    cm_if_lvl #(.CAPACITY(CAP)) lvl_if ();

    // the buffer side of the level interface
    assign lvl_if.lvl_gte = (lvl_if.lvl >= lvl_if.lvl_thr);

    cm_lvl_burst_ctl #(
        .CAPACITY (CAP),
        .TMO_CYC  (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lvl_if      (lvl_if),
        .i_en        (en),
        .i_cfg_thr   (cfg),
        .o_pop_vld   (pop_vld),
        .i_pop_rdy   (pop_rdy),
        .o_brst_act  (act),
        .o_brst_len  (len),
        .o_brst_done (done),
        .o_brst_tmo  (tmo)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int hs    = 0;
    int dn    = 0;

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, got, want, $time);
        end
    endtask

    // Model: beats still owed, cycles spent waiting, and stalled-level run length.
    int m_left = 0;
    int m_age  = -1;
    int m_thr  = CAP;
    int m_len  = 0;
    int m_tmo  = 0;
    int m_run  = 0;
    int m_lv;
    bit m_gte;

    function automatic int clampf(input int v);
        if (v == 0) return 1;
        if (v > CAP) return CAP;
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_age  = -1;
            m_thr  = CAP;
            m_len  = 0;
            m_tmo  = 0;
            m_run  = 0;
        end else if (m_left > 0) begin
            if (!lvl_if.lim && pop_rdy) m_left--;
            if (m_left == 0) begin
                if (en) begin
                    m_thr = clampf(int'(cfg));
                    m_age = 0;
                end else begin
                    m_age = -1;
                end
            end
        end else if (m_age >= 0) begin
            m_lv  = int'(lvl_if.lvl);
            m_gte = (m_lv >= m_thr);
            if (m_age >= 1 && m_gte) begin
                m_left = m_thr;
                m_len  = m_thr;
                m_tmo  = 0;
                m_age  = -1;
                m_run  = 0;
            end
`ifdef CM_LVL_BURST_TMO_EN
            else if (m_lv != 0 && m_run == TMO - 1) begin
                m_left = m_lv;
                m_len  = m_lv;
                m_tmo  = 1;
                m_age  = -1;
                m_run  = 0;
            end
`endif
            else begin
                m_age++;
                if (m_lv == 0) m_run = 0;
                else if (!m_gte) m_run++;
            end
        end else if (en) begin
            m_thr = clampf(int'(cfg));
            m_age = 0;
            m_run = 0;
        end
    end

    always @(negedge clk) begin
        chk("pop_vld", int'(pop_vld), int'(m_left > 0 && !lvl_if.lim));
        chk("brst_act", int'(act), int'(m_left > 0));
        chk("brst_done", int'(done),
            int'(m_left == 1 && !lvl_if.lim && pop_rdy));
        chk("brst_len", int'(len), m_len);
        chk("brst_tmo", int'(tmo), m_tmo);
        chk("lvl_thr", int'(lvl_if.lvl_thr), m_thr);
        if (pop_vld && pop_rdy) hs++;
        if (done) dn++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_act(input string nm, input int maxc);
        int i = 0;
        while (!act && i < maxc) begin
            step(1);
            i++;
        end
        if (!act) chk(nm, int'(act), 1);
    endtask

    task automatic wait_idle(input string nm, input int maxc);
        int i = 0;
        while (act && i < maxc) begin
            step(1);
            i++;
        end
        if (act) chk(nm, int'(act), 0);
    endtask

    task automatic wait_beats(input int h0, input int k);
        int i = 0;
        while (hs - h0 < k && i < 20) begin
            step(1);
            i++;
        end
        chk("beats_reached", hs - h0, k);
    endtask

    int h0;
    int d0;
    int n;

    initial begin
        rst         = 1'b1;
        en          = 1'b0;
        cfg         = '0;
        pop_rdy     = 1'b0;
        lvl_if.lim  = 1'b0;
        lvl_if.lvl  = '0;
        step(2);
        chk("rst_thr", int'(lvl_if.lvl_thr), 16);
        chk("rst_vld", int'(pop_vld), 0);
        chk("rst_act", int'(act), 0);
        chk("rst_len", int'(len), 0);
        rst = 1'b0;
        step(1);

        // level ramp up to the threshold, always-ready sink
        cfg = 5'd4; en = 1'b1; pop_rdy = 1'b1;
        step(1);
        en = 1'b0;
        chk("t1_thr", int'(lvl_if.lvl_thr), 4);
        h0 = hs; d0 = dn;
        for (int v = 1; v <= 3; v++) begin
            lvl_if.lvl = LW'(v);
            step(1);
        end
        lvl_if.lvl = 5'd4;
        #1;
        chk("t1_vld_pre", int'(pop_vld), 0);
        step(1);
        chk("t1_vld_lat", int'(pop_vld), 1);
        wait_idle("t1_end", 20);
        chk("t1_beats", hs - h0, 4);
        chk("t1_done", dn - d0, 1);
        chk("t1_len", int'(len), 4);

        // alternating ready
        cfg = 5'd4; en = 1'b1; pop_rdy = 1'b0;
        step(1);
        en = 1'b0;
        h0 = hs; d0 = dn;
        wait_act("t2_start", 10);
        for (int i = 0; i < 40 && act; i++) begin
            pop_rdy = (i % 2 == 0);
            step(1);
        end
        chk("t2_end", int'(act), 0);
        chk("t2_beats", hs - h0, 4);
        chk("t2_done", dn - d0, 1);

        // threshold clamping
        lvl_if.lvl = '0; pop_rdy = 1'b1; cfg = 5'd0; en = 1'b1;
        step(1);
        en = 1'b0;
        chk("t3_thr_lo", int'(lvl_if.lvl_thr), 1);
        lvl_if.lvl = 5'd4;
        h0 = hs;
        wait_act("t3a_start", 10);
        wait_idle("t3a_end", 10);
        chk("t3a_beats", hs - h0, 1);
        lvl_if.lvl = '0; cfg = 5'd20; en = 1'b1;
        step(1);
        en = 1'b0;
        chk("t3_thr_hi", int'(lvl_if.lvl_thr), 16);
        lvl_if.lvl = 5'd16;
        h0 = hs;
        wait_act("t3b_start", 10);
        wait_idle("t3b_end", 40);
        chk("t3b_beats", hs - h0, 16);
        chk("t3b_len", int'(len), 16);

        // source runs dry for three cycles after beat 2
        lvl_if.lvl = 5'd4; cfg = 5'd4; en = 1'b1;
        step(1);
        en = 1'b0;
        h0 = hs; d0 = dn;
        wait_act("t4_start", 10);
        wait_beats(h0, 2);
        lvl_if.lim = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_gated", int'(pop_vld), 0);
            step(1);
        end
        lvl_if.lim = 1'b0;
        wait_idle("t4_end", 20);
        chk("t4_beats", hs - h0, 4);
        chk("t4_done", dn - d0, 1);

        // reset in the middle of a burst
        cfg = 5'd4; en = 1'b1;
        step(1);
        en = 1'b0;
        h0 = hs;
        wait_act("t5_start", 10);
        wait_beats(h0, 2);
        rst = 1'b1;
        #1;
        chk("t5_rst_vld", int'(pop_vld), 0);
        chk("t5_rst_act", int'(act), 0);
        chk("t5_rst_thr", int'(lvl_if.lvl_thr), 16);
        step(2);
        rst = 1'b0;
        step(5);
        chk("t5_idle_act", int'(act), 0);
        chk("t5_idle_beats", hs - h0, 2);

        // level stalls below threshold
        lvl_if.lvl = 5'd3; cfg = 5'd4; en = 1'b1;
        step(1);
        en = 1'b0;
        h0 = hs;
        n = 0;
        while (!act && n < 30) begin
            step(1);
            n++;
        end
`ifdef CM_LVL_BURST_TMO_EN
        chk("t6_arm_cycles", n, 8);
        chk("t6_tmo", int'(tmo), 1);
        chk("t6_len", int'(len), 3);
        wait_idle("t6_end", 20);
        chk("t6_beats", hs - h0, 3);
`else
        chk("t6_no_burst", int'(act), 0);
        chk("t6_no_pop", hs - h0, 0);
        chk("t6_tmo", int'(tmo), 0);
`endif

        step(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
